fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit_instr_len.sv | 25 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU: instruction type field codes,
// default widths and per-type hold counts used by fetch, control and bench.
package cpu_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int ADDR_BITS   = 5;

  localparam int CYC_STD   = 3;
  localparam int CYC_LOAD  = 4;
  localparam int CYC_STORE = 3;

  typedef logic [1:0] instr_type_t;

  localparam instr_type_t TYPE_HALT  = 2'b00;
  localparam instr_type_t TYPE_STD   = 2'b01;
  localparam instr_type_t TYPE_LOAD  = 2'b10;
  localparam instr_type_t TYPE_STORE = 2'b11;

  // Counter must hold the longest hold count plus the extra first-word cycle.
  function automatic int hold_cnt_bits(input int cyc_std, input int cyc_load,
                                       input int cyc_store);
    int longest;
    longest = cyc_std;
    if (cyc_load > longest) longest = cyc_load;
    if (cyc_store > longest) longest = cyc_store;
    return $clog2(longest + 2);
  endfunction

  localparam int CNT_BITS = hold_cnt_bits(CYC_STD, CYC_LOAD, CYC_STORE);

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port on one side, control-unit facing
// instruction outputs on the other. master = fetch unit, slave = its environment.
interface fetch_unit_if #(
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int ADDR_BITS   = cpu_pkg::ADDR_BITS
);

  logic                   en;
  logic [ADDR_BITS-1:0]   imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_BITS-1:0]   pc;
  logic                   issue;
  logic                   halted;

  modport master (
    input  en, imem_rdata,
    output imem_addr, instr, pc, issue, halted
  );

  modport slave (
    output en, imem_rdata,
    input  imem_addr, instr, pc, issue, halted
  );

endinterface

// File: rtl/fetch_unit_instr_len.sv
// Maps an instruction type field to the number of cycles the control unit
// needs to sequence it; halt words map to zero.
module instr_len
  import cpu_pkg::*;
#(
  parameter int CYC_STD   = cpu_pkg::CYC_STD,
  parameter int CYC_LOAD  = cpu_pkg::CYC_LOAD,
  parameter int CYC_STORE = cpu_pkg::CYC_STORE,
  parameter int CNT_BITS  = cpu_pkg::CNT_BITS
) (
  input  logic [1:0]          typ,
  output logic [CNT_BITS-1:0] len
);

  always_comb begin
    len = '0;
    case (typ)
      TYPE_STD:   len = CNT_BITS'(CYC_STD);
      TYPE_LOAD:  len = CNT_BITS'(CYC_LOAD);
      TYPE_STORE: len = CNT_BITS'(CYC_STORE);
      default:    len = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: prefetches from a 1-cycle synchronous ROM and holds
// each word on instr for as long as the control unit needs, stopping on halt.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int ADDR_BITS   = cpu_pkg::ADDR_BITS,
  parameter int CYC_STD     = cpu_pkg::CYC_STD,
  parameter int CYC_LOAD    = cpu_pkg::CYC_LOAD,
  parameter int CYC_STORE   = cpu_pkg::CYC_STORE
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = hold_cnt_bits(CYC_STD, CYC_LOAD, CYC_STORE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       new_len;
  logic [1:0]             new_type;
  logic                   new_is_halt;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_BITS-1:0]   pc_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   issue_q;
  logic                   halted_q;

  assign new_type    = bus.imem_rdata[INSTR_WIDTH-1 -: 2];
  assign new_is_halt = (new_type == TYPE_HALT);

  instr_len #(
    .CYC_STD   (CYC_STD),
    .CYC_LOAD  (CYC_LOAD),
    .CYC_STORE (CYC_STORE),
    .CNT_BITS  (CNT_W)
  ) u_len (
    .typ (new_type),
    .len (new_len)
  );

  // imem_addr always runs one word ahead of pc, so rdata already holds the
  // next word when the hold counter reaches 1 and there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      issue_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      issue_q <= 1'b0;
      case (state)
        S_IDLE: begin
          addr_q <= '0;
          if (bus.en) state <= S_PRIME;
        end

        S_PRIME: begin
          issue_q <= 1'b1;
          pc_q    <= '0;
          if (new_is_halt) begin
            instr_q  <= '0;
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            // One extra cycle lets the control unit leave reset for DECODE.
            instr_q <= bus.imem_rdata;
            addr_q  <= ADDR_BITS'(1);
            cnt     <= new_len + 1'b1;
            state   <= S_RUN;
          end
        end

        S_RUN: begin
          if (cnt == CNT_W'(1)) begin
            issue_q <= 1'b1;
            pc_q    <= pc_q + 1'b1;
            if (new_is_halt) begin
              instr_q  <= '0;
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              instr_q <= bus.imem_rdata;
              addr_q  <= addr_q + 1'b1;
              cnt     <= new_len;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr     = instr_q;
  assign bus.pc        = pc_q;
  assign bus.imem_addr = addr_q;
  assign bus.issue     = issue_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, mixed types, ignored en, halt at 0,
// address wrap-around and asynchronous reset in the middle of a hold.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [INSTR_WIDTH-1:0] rom [32];

  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  int compared   = 0;
  int mismatched = 0;
  logic [INSTR_WIDTH-1:0] curInstrExp;
  bit toggleEn;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fillRom(input logic [INSTR_WIDTH-1:0] w);
    for (int i = 0; i < 32; i++) rom[i] = w;
  endtask

  task automatic doReset(input string tag);
    bus.en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_rst_instr"}, 32'(bus.instr), 32'h0);
    checkOutput({tag, "_rst_pc"}, 32'(bus.pc), 32'h0);
    checkOutput({tag, "_rst_addr"}, 32'(bus.imem_addr), 32'h0);
    checkOutput({tag, "_rst_issue"}, 32'(bus.issue), 32'h0);
    checkOutput({tag, "_rst_halted"}, 32'(bus.halted), 32'h0);
    rst = 1'b0;
    curInstrExp = '0;
  endtask

  // Raise en on a falling edge so the next rising edge samples it.
  task automatic applyStimulus();
    @(negedge clk);
    bus.en = 1'b1;
  endtask

  task automatic waitIssue(input int budget, output int gap);
    gap = 0;
    forever begin
      @(negedge clk);
      gap++;
      if (toggleEn) bus.en = ~bus.en;
      else bus.en = 1'b0;
      if (bus.issue === 1'b1) break;
      checkOutput("hold_instr", 32'(bus.instr), 32'(curInstrExp));
      if (gap >= budget) begin
        checkOutput("issue_timeout", 32'(gap), 32'(budget + 1));
        break;
      end
    end
  endtask

  task automatic expectIssue(input string tag, input int expGap,
                             input logic [INSTR_WIDTH-1:0] expInstr,
                             input logic [ADDR_BITS-1:0] expPc,
                             input logic [ADDR_BITS-1:0] expAddr,
                             input logic expHalted);
    int gap;
    waitIssue(12, gap);
    checkOutput({tag, "_gap"}, 32'(gap), 32'(expGap));
    checkOutput({tag, "_instr"}, 32'(bus.instr), 32'(expInstr));
    checkOutput({tag, "_pc"}, 32'(bus.pc), 32'(expPc));
    checkOutput({tag, "_addr"}, 32'(bus.imem_addr), 32'(expAddr));
    checkOutput({tag, "_halted"}, 32'(bus.halted), 32'(expHalted));
    curInstrExp = expInstr;
  endtask

  task automatic checkQuiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.issue === 1'b1) pulses++;
    end
    checkOutput({tag, "_no_issue"}, 32'(pulses), 32'h0);
    checkOutput({tag, "_halted_hold"}, 32'(bus.halted), 32'h1);
    checkOutput({tag, "_instr_zero"}, 32'(bus.instr), 32'h0);
  endtask

  task automatic runMixed(input string tag);
    fillRom('0);
    rom[0] = 20'h4_1230;
    rom[1] = 20'h8_0005;
    rom[2] = 20'hC_0007;
    rom[3] = 20'h4_0ABC;
    rom[4] = 20'h0_1234;
    doReset(tag);
    applyStimulus();
    expectIssue({tag, "_w0"}, 2, 20'h4_1230, 5'd0, 5'd1, 1'b0);
    expectIssue({tag, "_w1"}, 4, 20'h8_0005, 5'd1, 5'd2, 1'b0);
    expectIssue({tag, "_w2"}, 4, 20'hC_0007, 5'd2, 5'd3, 1'b0);
    expectIssue({tag, "_w3"}, 3, 20'h4_0ABC, 5'd3, 5'd4, 1'b0);
    expectIssue({tag, "_halt"}, 3, 20'h0, 5'd4, 5'd4, 1'b1);
    checkQuiet(tag, 6);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [INSTR_WIDTH-1:0] w;
    rst = 1'b1;
    bus.en = 1'b0;
    toggleEn = 1'b0;
    curInstrExp = '0;
    fillRom('0);

    // Startup: std word then halt; IDLE must keep instr and address at zero.
    rom[0] = 20'h4_1230;
    rom[1] = 20'h0_0000;
    doReset("start");
    repeat (3) @(negedge clk);
    checkOutput("idle_instr", 32'(bus.instr), 32'h0);
    checkOutput("idle_addr", 32'(bus.imem_addr), 32'h0);
    checkOutput("idle_issue", 32'(bus.issue), 32'h0);
    applyStimulus();
    expectIssue("start_w0", 2, 20'h4_1230, 5'd0, 5'd1, 1'b0);
    expectIssue("start_halt", 4, 20'h0, 5'd1, 5'd1, 1'b1);
    checkQuiet("start", 5);

    runMixed("mix");

    toggleEn = 1'b1;
    runMixed("ign");
    toggleEn = 1'b0;

    // Halt word at address 0.
    fillRom('0);
    doReset("h0");
    applyStimulus();
    expectIssue("h0_halt", 2, 20'h0, 5'd0, 5'd0, 1'b1);
    checkQuiet("h0", 8);

    // Wrap-around: ROM[2] becomes a halt only once the second lap is near.
    for (int i = 0; i < 32; i++) rom[i] = 20'h4_0000 | 20'(i);
    doReset("wrap");
    applyStimulus();
    expectIssue("wrap_w0", 2, 20'h4_0000, 5'd0, 5'd1, 1'b0);
    for (int k = 1; k < 32; k++) begin
      w = 20'h4_0000 | 20'(k);
      expectIssue($sformatf("wrap_w%0d", k), (k == 1) ? 4 : 3, w,
                  5'(k), 5'(k + 1), 1'b0);
      if (k == 30) rom[2] = 20'h0_0002;
    end
    expectIssue("wrap_lap_w0", 3, 20'h4_0000, 5'd0, 5'd1, 1'b0);
    expectIssue("wrap_lap_w1", 3, 20'h4_0001, 5'd1, 5'd2, 1'b0);
    expectIssue("wrap_halt", 3, 20'h0, 5'd2, 5'd2, 1'b1);
    checkQuiet("wrap", 4);

    // Reset asserted in the second cycle of a loadR hold.
    fillRom('0);
    rom[0] = 20'h4_1230;
    rom[1] = 20'h8_0005;
    rom[2] = 20'h4_0001;
    doReset("rmh");
    applyStimulus();
    expectIssue("rmh_w0", 2, 20'h4_1230, 5'd0, 5'd1, 1'b0);
    expectIssue("rmh_w1", 4, 20'h8_0005, 5'd1, 5'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rmh_async_instr", 32'(bus.instr), 32'h0);
    checkOutput("rmh_async_pc", 32'(bus.pc), 32'h0);
    checkOutput("rmh_async_addr", 32'(bus.imem_addr), 32'h0);
    checkOutput("rmh_async_issue", 32'(bus.issue), 32'h0);
    checkOutput("rmh_async_halted", 32'(bus.halted), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    curInstrExp = '0;
    applyStimulus();
    expectIssue("rmh_restart_w0", 2, 20'h4_1230, 5'd0, 5'd1, 1'b0);
    expectIssue("rmh_restart_w1", 4, 20'h8_0005, 5'd1, 5'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
